// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow finish in one cycle.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      div_op_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] div_data_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r, state_next_s;
    logic [1:0]      op_r;
    logic [XLEN-1:0] dvd_r;       // dividend magnitude; quotient bits shift in from the LSB
    logic [XLEN-1:0] dsr_r;
    logic [XLEN-1:0] rem_r;
    logic [CW-1:0]   cnt_r;
    logic            neg_q_r;
    logic            neg_r_r;
    logic            busy_r;
    logic            valid_r;
    logic [XLEN-1:0] data_r;

    logic            signed_op_s;
    logic            a_neg_s;
    logic            b_neg_s;
    logic            div_zero_s;
    logic            ovf_s;
    logic            special_s;
    logic [XLEN-1:0] special_data_s;
    logic [XLEN:0]   rem_shift_s;
    logic [XLEN:0]   diff_s;
    logic            ge_s;
    logic [XLEN-1:0] rem_next_s;
    logic [XLEN-1:0] quo_next_s;
    logic [XLEN-1:0] result_s;

    function automatic logic [XLEN-1:0] neg_if(input logic cond, input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        if (cond) begin
            r = ~v + {{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Operand classification, one restoring step, and final sign fixup.
    always_comb begin
        signed_op_s    = ~div_op_i[0];
        a_neg_s        = signed_op_s & operand_a_i[XLEN-1];
        b_neg_s        = signed_op_s & operand_b_i[XLEN-1];
        div_zero_s     = (operand_b_i == {XLEN{1'b0}});
        ovf_s          = signed_op_s
                         && (operand_a_i == {1'b1, {(XLEN-1){1'b0}}})
                         && (operand_b_i == {XLEN{1'b1}});
        special_s      = div_zero_s | ovf_s;
        special_data_s = {XLEN{1'b0}};
        if (div_zero_s) begin
            special_data_s = div_op_i[1] ? operand_a_i : {XLEN{1'b1}};
        end else begin
            special_data_s = div_op_i[1] ? {XLEN{1'b0}} : operand_a_i;
        end

        // Wide partial remainder so DIVU divisors >= 2^(XLEN-1) cannot overflow
        rem_shift_s = {rem_r, dvd_r[XLEN-1]};
        diff_s      = rem_shift_s - {1'b0, dsr_r};
        ge_s        = ~diff_s[XLEN];
        if (ge_s) begin
            rem_next_s = diff_s[XLEN-1:0];
        end else begin
            rem_next_s = rem_shift_s[XLEN-1:0];
        end
        quo_next_s = {dvd_r[XLEN-2:0], ge_s};

        if (op_r[1]) begin
            result_s = neg_if(neg_r_r, rem_next_s);
        end else begin
            result_s = neg_if(neg_q_r, quo_next_s);
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_next_s = special_s ? DONE : CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = CALC;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, iteration datapath and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_r    <= 2'd0;
            dvd_r   <= {XLEN{1'b0}};
            dsr_r   <= {XLEN{1'b0}};
            rem_r   <= {XLEN{1'b0}};
            cnt_r   <= {CW{1'b0}};
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            data_r  <= {XLEN{1'b0}};
        end else begin
            busy_r  <= (state_next_s != IDLE);
            valid_r <= (state_next_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        op_r    <= div_op_i;
                        dvd_r   <= neg_if(a_neg_s, operand_a_i);
                        dsr_r   <= neg_if(b_neg_s, operand_b_i);
                        rem_r   <= {XLEN{1'b0}};
                        cnt_r   <= {CW{1'b0}};
                        neg_q_r <= a_neg_s ^ b_neg_s;
                        neg_r_r <= a_neg_s;
                        if (special_s) begin
                            data_r <= special_data_s;
                        end
                    end
                end
                CALC: begin
                    rem_r <= rem_next_s;
                    dvd_r <= quo_next_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        data_r <= result_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy_o     = busy_r;
    assign valid_o    = valid_r;
    assign div_data_o = data_r;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected results queued at acceptance,
// compared by a monitor whenever valid_o pulses; latency checked by the driver.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  div_op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        busy;
    logic        valid;
    logic [31:0] data;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb_q[$];

    div_unit #(.XLEN(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .div_op_i    (div_op),
        .operand_a_i (opa),
        .operand_b_i (opb),
        .busy_o      (busy),
        .valid_o     (valid),
        .div_data_o  (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
        case (op)
            2'd0:    return $signed(a) / $signed(b);
            2'd1:    return a / b;
            2'd2:    return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Scoreboard monitor: every valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                check("data", data, sb_q.pop_front());
            end
        end
    end

    // Drive one operation; poke injects ignored starts while busy and in the DONE cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input bit poke);
        int k;
        bit seen;
        @(negedge clk);
        start = 1'b1; div_op = op; opa = a; opb = b;
        @(posedge clk);
        sb_q.push_back(exp);
        @(negedge clk);
        start = 1'b0; opa = $urandom; opb = $urandom;
        k = 1;
        seen = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        while (!seen && k < 40) begin
            start = 1'b0;
            if (valid) begin
                seen = 1'b1;
                check("latency", k, lat);
                check("busy_in_done", {31'd0, busy}, 32'd1);
                if (poke) begin
                    start = 1'b1; div_op = 2'd1; opa = 32'd9; opb = 32'd3;
                end
            end else begin
                if (poke && k == 5) begin
                    start = 1'b1; div_op = 2'd1; opa = 32'd9; opb = 32'd3;
                end
                @(negedge clk);
                k++;
            end
        end
        if (!seen) begin
            check("timeout_latency", k, lat);
            void'(sb_q.pop_front());
        end
        @(negedge clk);
        start = 1'b0;
        check("valid_one_cycle", {31'd0, valid}, 32'd0);
        check("data_held", data, exp);
        check("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        rst = 1'b1; start = 1'b0; div_op = 2'd0; opa = 32'd0; opb = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_data", data, 32'd0);
        rst = 1'b0;

        run_op(2'd1, 32'd100, 32'd7, 32'd14, 33, 1'b0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
        run_op(2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
        run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 33, 1'b0);
        run_op(2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
        run_op(2'd2, 32'd5, 32'd0, 32'd5, 1, 1'b0);
        run_op(2'd1, 32'd0, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
        run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
        run_op(2'd3, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33, 1'b0);
        run_op(2'd1, 32'd0, 32'd1, 32'd0, 33, 1'b0);

        // Starts while busy and during DONE are dropped; the next start goes through.
        run_op(2'd1, 32'd100, 32'd7, 32'd14, 33, 1'b1);
        run_op(2'd1, 32'd9, 32'd3, 32'd3, 33, 1'b0);

        for (int i = 0; i < 8; i++) begin
            op = 2'(i % 4);
            a  = $urandom;
            b  = (i < 4) ? 32'($urandom_range(1, 15)) : $urandom;
            if (i == 5) b = 32'hFFFF_FFFF;
            run_op(op, a, b, ref_div(op, a, b), ref_lat(op, a, b), 1'b0);
        end

        // Reset mid-operation: outputs clear and no result is ever delivered.
        @(negedge clk);
        start = 1'b1; div_op = 2'd0; opa = 32'd1000; opb = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid", {31'd0, valid}, 32'd0);
        check("abort_data", data, 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        run_op(2'd0, 32'hFFFF_FC18, 32'd7, 32'hFFFF_FF72, 33, 1'b0);
        check("sb_empty", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
